// File: rtl/dnn_pkg.sv
// dnn_pkg: shared FSM state type and index width helper for the weight path
package dnn_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  function automatic int width_of(input int x);
    return (x > 2) ? $clog2(x) : 1;
  endfunction
endpackage

// File: rtl/weight_loader_index_counter.sv
// index_counter: nested k_x -> k_y -> out -> in wrap counter with last-position flag
module index_counter
  import dnn_pkg::*;
#(
  parameter int NUM_INPUTS  = 1,
  parameter int NUM_OUTPUTS = 1,
  parameter int DIM         = 1,
  localparam int IW = width_of(NUM_INPUTS),
  localparam int OW = width_of(NUM_OUTPUTS),
  localparam int KW = width_of(DIM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [IW-1:0] index_in,
  output logic [OW-1:0] index_out,
  output logic [KW-1:0] index_k_y,
  output logic [KW-1:0] index_k_x,
  output logic          last
);
  logic wx, wy, wo, wi;
  always_comb begin
    wx = index_k_x == KW'(DIM - 1);
    wy = index_k_y == KW'(DIM - 1);
    wo = index_out == OW'(NUM_OUTPUTS - 1);
    wi = index_in == IW'(NUM_INPUTS - 1);
    last = wx && wy && wo && wi;
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      index_in  <= '0;
      index_out <= '0;
      index_k_y <= '0;
      index_k_x <= '0;
    end else if (inc) begin
      index_k_x <= wx ? '0 : index_k_x + 1'b1;
      if (wx) index_k_y <= wy ? '0 : index_k_y + 1'b1;
      if (wx && wy) index_out <= wo ? '0 : index_out + 1'b1;
      if (wx && wy && wo) index_in <= wi ? '0 : index_in + 1'b1;
    end
  end
endmodule

// File: rtl/weight_loader.sv
// weight_loader: turns a valid/ready weight stream into indexed single-cycle memory writes
module weight_loader
  import dnn_pkg::*;
#(
  parameter int NUM_INPUTS  = 1,
  parameter int NUM_OUTPUTS = 1,
  parameter int DIM         = 1,
  parameter int DATA_SIZE   = 64,
  localparam int IW    = width_of(NUM_INPUTS),
  localparam int OW    = width_of(NUM_OUTPUTS),
  localparam int KW    = width_of(DIM),
  localparam int TOTAL = NUM_INPUTS * NUM_OUTPUTS * DIM * DIM,
  localparam int CW    = $clog2(TOTAL + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 write,
  output logic [IW-1:0]        index_in,
  output logic [OW-1:0]        index_out,
  output logic [KW-1:0]        index_k_y,
  output logic [KW-1:0]        index_k_x,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        count,
  output logic                 overflow
);
  state_t state, next_state;
  logic accept, clear, last;
  logic [IW-1:0] c_in;
  logic [OW-1:0] c_out;
  logic [KW-1:0] c_k_y, c_k_x;
  index_counter #(
    .NUM_INPUTS (NUM_INPUTS),
    .NUM_OUTPUTS(NUM_OUTPUTS),
    .DIM        (DIM)
  ) u_index_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .inc      (accept),
    .index_in (c_in),
    .index_out(c_out),
    .index_k_y(c_k_y),
    .index_k_x(c_k_x),
    .last     (last)
  );
  always_comb begin
    in_ready   = state == LOAD;
    busy       = state == LOAD;
    done       = state == DONE;
    accept     = in_valid && in_ready;
    clear      = start && !abort && state != LOAD;
    next_state = abort ? IDLE : clear ? LOAD : (accept && last) ? DONE : state;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : next_state;
  always_ff @(posedge clk) begin
    if (reset) begin
      write     <= 1'b0;
      index_in  <= '0;
      index_out <= '0;
      index_k_y <= '0;
      index_k_x <= '0;
      out_data  <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      write <= accept;
      if (accept) begin
        index_in  <= c_in;
        index_out <= c_out;
        index_k_y <= c_k_y;
        index_k_x <= c_k_x;
        out_data  <= in_data;
      end
      count    <= clear ? '0 : accept ? count + 1'b1 : count;
      overflow <= clear ? 1'b0 : (in_valid && state != LOAD) ? 1'b1 : overflow;
    end
  end
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: scoreboard-checked directed sequence for weight_loader (2x3x3x3, 54 words)
module tb_weight_loader;
  localparam int NI = 2, NO = 3, DM = 3, DS = 64, TOTAL = 54;
  logic clk, reset, start, abort, in_valid, in_ready, write, busy, done, overflow;
  logic [DS-1:0] in_data, out_data;
  logic [0:0] index_in;
  logic [1:0] index_out, index_k_y, index_k_x;
  logic [5:0] count;
  logic [70:0] sb[$];
  int tests, fails, writes, k, w0;
  logic loading;
  weight_loader #(
    .NUM_INPUTS (NI),
    .NUM_OUTPUTS(NO),
    .DIM        (DM),
    .DATA_SIZE  (DS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .write    (write),
    .index_in (index_in),
    .index_out(index_out),
    .index_k_y(index_k_y),
    .index_k_x(index_k_x),
    .out_data (out_data),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .overflow (overflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [70:0] exp_word(input int n);
    return {1'(n / 27), 2'((n / 9) % 3), 2'((n / 3) % 3), 2'(n % 3), $realtobits(n * 0.5)};
  endfunction
  always @(negedge clk) begin
    if (write === 1'b1) begin
      writes++;
      chk("write_expected", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0) chk("write_pos_data", {index_in, index_out, index_k_y, index_k_x, out_data}, sb.pop_front());
    end
  end
  task automatic drive(input logic v);
    in_valid = v;
    in_data  = $realtobits(k * 0.5);
    if (v && loading) begin
      sb.push_back(exp_word(k));
      k++;
      if (k == TOTAL) loading = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    loading = 1'b1;
    k = 0;
  endtask
  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    loading = 1'b0;
  endtask
  initial begin
    tests = 0; fails = 0; writes = 0; k = 0; loading = 1'b0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {write, busy, done, overflow, in_ready, count, index_in, index_out, index_k_y, index_k_x, out_data}, 0);
    reset = 1'b0;
    @(negedge clk);
    do_start();
    chk("t1_busy", {busy, in_ready, done}, 3'b110);
    w0 = writes;
    for (int i = 0; i < TOTAL; i++) drive(1'b1);
    chk("t1_final_write", write, 1);
    chk("t1_done", {done, busy, in_ready}, 3'b100);
    chk("t1_count", count, TOTAL);
    @(negedge clk);
    chk("t1_writes", writes - w0, TOTAL);
    w0 = writes;
    do_start();
    for (int i = 0; i < 10; i++) drive(1'b1);
    do_abort();
    chk("t3_idle", {busy, done, in_ready}, 3'b000);
    chk("t3_count", count, 10);
    @(negedge clk);
    chk("t3_writes", writes - w0, 10);
    do_start();
    chk("t3_restart_count", count, 0);
    drive(1'b1);
    @(negedge clk);
    chk("t3_restart_one", count, 1);
    do_abort();
    drive(1'b1);
    chk("t4_idle_overflow", {overflow, in_ready, write, count}, {3'b100, 6'd1});
    do_start();
    chk("t4_start_clears", overflow, 0);
    w0 = writes;
    for (int i = 0; i < 1000 && k < TOTAL; i++) drive(1'($urandom_range(0, 1)));
    chk("t2_all_accepted", k, TOTAL);
    @(negedge clk);
    chk("t2_writes", writes - w0, TOTAL);
    chk("t2_done", {done, count}, {1'b1, 6'd54});
    drive(1'b1);
    chk("t4_done_overflow", {overflow, in_ready, write, done}, 4'b1001);
    do_start();
    chk("t4_restart_clears", {overflow, count}, 0);
    for (int i = 0; i < 20; i++) drive(1'b1);
    in_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    loading = 1'b0;
    k = 0;
    chk("t5_reset_outputs", {write, busy, done, overflow, in_ready, count, index_in, index_out, index_k_y, index_k_x, out_data}, 0);
    chk("t5_queue_drained", sb.size(), 0);
    @(negedge clk);
    chk("t5_not_ready", {in_ready, write}, 0);
    do_start();
    w0 = writes;
    for (int i = 0; i < TOTAL; i++) begin
      if (i == 30) start = 1'b1;
      drive(1'b1);
      start = 1'b0;
    end
    chk("t6_done", {done, count}, {1'b1, 6'd54});
    @(negedge clk);
    chk("t6_writes", writes - w0, TOTAL);
    chk("final_queue_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
